// File: rtl/calc_pkg.sv
// Shared types, status encodings and active-low 7-segment glyphs for the calculator display path.
package calc_pkg;

    localparam logic [1:0] ST_ERRO    = 2'b00;
    localparam logic [1:0] ST_OCUPADO = 2'b01;
    localparam logic [1:0] ST_PRONTO  = 2'b10;

    localparam int NUM_DIGITS = 8;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] glyph_t;

    // Bit order {a,b,c,d,e,f,g}; a cleared bit lights the segment.
    localparam glyph_t GLYPH_0     = 7'b0000001;
    localparam glyph_t GLYPH_1     = 7'b1001111;
    localparam glyph_t GLYPH_2     = 7'b0010010;
    localparam glyph_t GLYPH_3     = 7'b0000110;
    localparam glyph_t GLYPH_4     = 7'b1001100;
    localparam glyph_t GLYPH_5     = 7'b0100100;
    localparam glyph_t GLYPH_6     = 7'b0100000;
    localparam glyph_t GLYPH_7     = 7'b0001111;
    localparam glyph_t GLYPH_8     = 7'b0000000;
    localparam glyph_t GLYPH_9     = 7'b0000100;
    localparam glyph_t GLYPH_E     = 7'b0110000;
    localparam glyph_t GLYPH_R     = 7'b1111010;
    localparam glyph_t GLYPH_O     = 7'b1100010;
    localparam glyph_t GLYPH_BLANK = 7'b1111111;

endpackage

// File: rtl/calc_display_seg7_decode.sv
// Combinational digit-to-glyph decoder; in error mode the digit input carries the
// scan position and selects the "Erro" letters (positions 0..3 = o, r, r, E).
module seg7_decode
    import calc_pkg::*;
(
    input  digit_t digit_i,
    input  logic   blank_i,
    input  logic   err_sel_i,
    output glyph_t seg_o
);

    always_comb begin
        seg_o = GLYPH_BLANK;
        if (err_sel_i) begin
            case (digit_i)
                4'd0:       seg_o = GLYPH_O;
                4'd1, 4'd2: seg_o = GLYPH_R;
                4'd3:       seg_o = GLYPH_E;
                default:    seg_o = GLYPH_BLANK;
            endcase
        end else if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = GLYPH_0;
                4'd1:    seg_o = GLYPH_1;
                4'd2:    seg_o = GLYPH_2;
                4'd3:    seg_o = GLYPH_3;
                4'd4:    seg_o = GLYPH_4;
                4'd5:    seg_o = GLYPH_5;
                4'd6:    seg_o = GLYPH_6;
                4'd7:    seg_o = GLYPH_7;
                4'd8:    seg_o = GLYPH_8;
                4'd9:    seg_o = GLYPH_9;
                default: seg_o = GLYPH_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/calc_display.sv
// Captures calculator digit writes into a shadow frame, commits it on busy->ready,
// and scans the committed digits onto common-anode 7-segment displays (1-cycle output latency, no backpressure).
module calc_display
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] pos,
    input  logic [3:0] data,
    output logic [6:0] seg,
    output logic [7:0] an,
    output logic       err,
    output logic       shown
);

    localparam int DIV_W = $clog2(REFRESH_DIV);

    digit_t           shadow_q [NUM_DIGITS];
    digit_t           disp_q   [NUM_DIGITS];
    logic [1:0]       status_q;
    logic             err_q;
    logic             shown_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    glyph_t           seg_q, seg_d;
    logic [7:0]       an_q;

    logic                  wr_en;
    logic                  commit;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  above_empty;
    digit_t                dec_digit;

    assign wr_en  = (status == ST_OCUPADO) && !pos[3];
    // Ready is any status with bit 1 set (reserved 11 behaves as ready).
    assign commit = (status_q == ST_OCUPADO) && status[1] && !err_q;

    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    // Walk down from the top digit; a zero is blanked while everything above it is zero or blank.
    always_comb begin
        lz_blank    = '0;
        above_empty = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_blank[i] = BLANK_LZ && (disp_q[i] == 4'd0) && above_empty;
            above_empty = above_empty && ((disp_q[i] == 4'd0) || (disp_q[i] >= 4'd10));
        end
    end

    assign dec_digit = err_q ? digit_t'({1'b0, idx_q}) : disp_q[idx_q];

    seg7_decode u_dec (
        .digit_i   (dec_digit),
        .blank_i   (lz_blank[idx_q]),
        .err_sel_i (err_q),
        .seg_o     (seg_d)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= '0;
                disp_q[i]   <= '0;
            end
            status_q <= ST_ERRO;
            err_q    <= 1'b0;
            shown_q  <= 1'b0;
            div_q    <= '0;
            idx_q    <= '0;
            seg_q    <= GLYPH_BLANK;
            an_q     <= 8'hFF;
        end else begin
            if (wr_en) begin
                shadow_q[pos[2:0]] <= data;
            end
            if (commit) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    disp_q[i] <= shadow_q[i];
                end
            end
            status_q <= status;
            err_q    <= err_q | (status == ST_ERRO);
            shown_q  <= commit;
            div_q    <= div_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            an_q     <= ~(8'd1 << idx_q);
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign err   = err_q;
    assign shown = shown_q;

endmodule
